// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: hazard controller for a 5-stage in-order pipeline.
// Drives the front-end hold, the ID/EX bubble, the EX operand forwarding
// selects and a global freeze for data-memory waits. It tracks a single
// outstanding multi-cycle (mul/div) result in a small scoreboard and keeps
// two saturating performance counters.
module hazard_fwd_unit #(
    parameter int REG_AW   = 5,
    parameter int NUM_REGS = 32,
    parameter bit FWD_EN   = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] rs1_id,
    input  logic [REG_AW-1:0] rs2_id,
    input  logic [REG_AW-1:0] rd_id,
    input  logic              rs1_used,
    input  logic              rs2_used,
    input  logic              regwrite_id,
    input  logic              id_is_mc,
    input  logic [REG_AW-1:0] rs1_ex,
    input  logic [REG_AW-1:0] rs2_ex,
    input  logic [REG_AW-1:0] rd_ex,
    input  logic [REG_AW-1:0] rd_mem,
    input  logic [REG_AW-1:0] rd_wb,
    input  logic              regwrite_ex,
    input  logic              regwrite_mem,
    input  logic              regwrite_wb,
    input  logic              mem_read_ex,
    input  logic              mem_req_mem,
    input  logic              mem_ready,
    input  logic              mc_issue,
    input  logic [REG_AW-1:0] mc_rd,
    input  logic              mc_done,
    output logic              stall_front,
    output logic              bubble_ex,
    output logic              freeze,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              mc_busy,
    output logic              err,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  loaduse_cnt
);

    localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_e;

    // Operand select for one EX source: the youngest producer (MEM) wins over
    // WB, and x0 is hard-wired so it is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic              wr_mem,
        input logic [REG_AW-1:0] dst_mem,
        input logic              wr_wb,
        input logic [REG_AW-1:0] dst_wb
    );
        logic [1:0] sel;
        if (rs == REG_ZERO) begin
            sel = 2'b00;
        end else if (wr_mem && (dst_mem == rs)) begin
            sel = 2'b10;
        end else if (wr_wb && (dst_wb == rs)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // True when any later stage will write the given source register.
    function automatic logic stage_writes(input logic [REG_AW-1:0] src);
        return (regwrite_ex  && (rd_ex  == src)) ||
               (regwrite_mem && (rd_mem == src)) ||
               (regwrite_wb  && (rd_wb  == src));
    endfunction

    state_e               state_q, state_d;
    logic [NUM_REGS-1:0]  pending_q, pending_d;
    logic                 mc_busy_q, mc_busy_d;
    logic                 err_q, err_d;
    logic [CNT_W-1:0]     stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0]     loaduse_cnt_q, loaduse_cnt_d;

    logic                 rs1_chk, rs2_chk;
    logic                 raw_hit, load_use, sb_hit, struct_hit, hazard;

    // EX operand forwarding selects; disabled builds always read the regfile.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (FWD_EN) begin
            fwd_a = fwd_sel(rs1_ex, regwrite_mem, rd_mem, regwrite_wb, rd_wb);
            fwd_b = fwd_sel(rs2_ex, regwrite_mem, rd_mem, regwrite_wb, rd_wb);
        end else begin
            fwd_a = 2'b00;
            fwd_b = 2'b00;
        end
    end

    // Hazard detection and the resulting stall/bubble/freeze controls.
    always_comb begin
        rs1_chk  = id_valid && rs1_used && (rs1_id != REG_ZERO);
        rs2_chk  = id_valid && rs2_used && (rs2_id != REG_ZERO);
        load_use = 1'b0;
        raw_hit  = 1'b0;
        if (FWD_EN) begin
            // Only a load in EX cannot be covered by forwarding.
            load_use = mem_read_ex &&
                       ((rs1_chk && (rd_ex == rs1_id)) ||
                        (rs2_chk && (rd_ex == rs2_id)));
            raw_hit  = load_use;
        end else begin
            load_use = 1'b0;
            raw_hit  = (rs1_chk && stage_writes(rs1_id)) ||
                       (rs2_chk && stage_writes(rs2_id));
        end
        // pending_q[0] is never set, so x0 never hits the scoreboard.
        sb_hit     = id_valid &&
                     ((rs1_used    && pending_q[rs1_id]) ||
                      (rs2_used    && pending_q[rs2_id]) ||
                      (regwrite_id && pending_q[rd_id]));
        struct_hit = id_valid && id_is_mc && mc_busy_q;
        hazard     = raw_hit || sb_hit || struct_hit;
        // Freeze is decoded straight from MEM so it covers the first wait cycle.
        freeze      = mem_req_mem && !mem_ready;
        stall_front = hazard || freeze;
        bubble_ex   = hazard && !freeze;
    end

    // Next state for the memory-wait tracker, scoreboard, error flag and counters.
    always_comb begin
        state_d        = state_q;
        pending_d      = pending_q;
        mc_busy_d      = mc_busy_q;
        err_d          = err_q;
        stall_cycles_d = stall_cycles_q;
        loaduse_cnt_d  = loaduse_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (mem_req_mem && !mem_ready) begin
                    state_d = ST_MEM_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_MEM_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A second issue while one op is outstanding is a protocol error.
        if (mc_issue && mc_busy_q) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end

        if (mc_busy_q && mc_done) begin
            pending_d = {NUM_REGS{1'b0}};
            mc_busy_d = 1'b0;
        end else if (!mc_busy_q && mc_issue && (mc_rd != REG_ZERO)) begin
            pending_d[mc_rd] = 1'b1;
            mc_busy_d        = 1'b1;
        end else begin
            pending_d = pending_q;
            mc_busy_d = mc_busy_q;
        end

        if (stall_front && (stall_cycles_q != CNT_MAX)) begin
            stall_cycles_d = stall_cycles_q + CNT_ONE;
        end else begin
            stall_cycles_d = stall_cycles_q;
        end

        if (load_use && (loaduse_cnt_q != CNT_MAX)) begin
            loaduse_cnt_d = loaduse_cnt_q + CNT_ONE;
        end else begin
            loaduse_cnt_d = loaduse_cnt_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            pending_q      <= {NUM_REGS{1'b0}};
            mc_busy_q      <= 1'b0;
            err_q          <= 1'b0;
            stall_cycles_q <= {CNT_W{1'b0}};
            loaduse_cnt_q  <= {CNT_W{1'b0}};
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            mc_busy_q      <= mc_busy_d;
            err_q          <= err_d;
            stall_cycles_q <= stall_cycles_d;
            loaduse_cnt_q  <= loaduse_cnt_d;
        end
    end

    assign mc_busy      = mc_busy_q;
    assign err          = err_q;
    assign stall_cycles = stall_cycles_q;
    assign loaduse_cnt  = loaduse_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit. Three builds share one stimulus
// stream: forwarding with wide counters, no forwarding with 4-bit counters
// and forwarding with 3-bit counters (so saturation is reachable).
module tb_hazard_fwd_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, rs1_used, rs2_used, regwrite_id, id_is_mc;
    logic [4:0] rs1_id, rs2_id, rd_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb, mc_rd;
    logic       regwrite_ex, regwrite_mem, regwrite_wb;
    logic       mem_read_ex, mem_req_mem, mem_ready, mc_issue, mc_done;

    logic        sf0, bf0, fz0, mb0, er0;
    logic [1:0]  fa0, fb0;
    logic [15:0] sc0, lc0;
    logic        sf1, bf1, fz1, mb1, er1;
    logic [1:0]  fa1, fb1;
    logic [3:0]  sc1, lc1;
    logic        sf2, bf2, fz2, mb2, er2;
    logic [1:0]  fa2, fb2;
    logic [2:0]  sc2, lc2;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    // Reference model: one pending register number (0 = none) per build.
    int fen  [3] = '{1, 0, 1};
    int cmax [3] = '{65535, 15, 7};
    int m_busy [3];
    int m_pend [3];
    int m_err  [3];
    int m_sc   [3];
    int m_lc   [3];

    always #5 clk = ~clk;

    hazard_fwd_unit #(.REG_AW(5), .NUM_REGS(32), .FWD_EN(1'b1), .CNT_W(16)) u0 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rd_id(rd_id), .rs1_used(rs1_used), .rs2_used(rs2_used), .regwrite_id(regwrite_id),
        .id_is_mc(id_is_mc), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex), .rd_mem(rd_mem),
        .rd_wb(rd_wb), .regwrite_ex(regwrite_ex), .regwrite_mem(regwrite_mem),
        .regwrite_wb(regwrite_wb), .mem_read_ex(mem_read_ex), .mem_req_mem(mem_req_mem),
        .mem_ready(mem_ready), .mc_issue(mc_issue), .mc_rd(mc_rd), .mc_done(mc_done),
        .stall_front(sf0), .bubble_ex(bf0), .freeze(fz0), .fwd_a(fa0), .fwd_b(fb0),
        .mc_busy(mb0), .err(er0), .stall_cycles(sc0), .loaduse_cnt(lc0));

    hazard_fwd_unit #(.REG_AW(5), .NUM_REGS(32), .FWD_EN(1'b0), .CNT_W(4)) u1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rd_id(rd_id), .rs1_used(rs1_used), .rs2_used(rs2_used), .regwrite_id(regwrite_id),
        .id_is_mc(id_is_mc), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex), .rd_mem(rd_mem),
        .rd_wb(rd_wb), .regwrite_ex(regwrite_ex), .regwrite_mem(regwrite_mem),
        .regwrite_wb(regwrite_wb), .mem_read_ex(mem_read_ex), .mem_req_mem(mem_req_mem),
        .mem_ready(mem_ready), .mc_issue(mc_issue), .mc_rd(mc_rd), .mc_done(mc_done),
        .stall_front(sf1), .bubble_ex(bf1), .freeze(fz1), .fwd_a(fa1), .fwd_b(fb1),
        .mc_busy(mb1), .err(er1), .stall_cycles(sc1), .loaduse_cnt(lc1));

    hazard_fwd_unit #(.REG_AW(5), .NUM_REGS(32), .FWD_EN(1'b1), .CNT_W(3)) u2 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rd_id(rd_id), .rs1_used(rs1_used), .rs2_used(rs2_used), .regwrite_id(regwrite_id),
        .id_is_mc(id_is_mc), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex), .rd_mem(rd_mem),
        .rd_wb(rd_wb), .regwrite_ex(regwrite_ex), .regwrite_mem(regwrite_mem),
        .regwrite_wb(regwrite_wb), .mem_read_ex(mem_read_ex), .mem_req_mem(mem_req_mem),
        .mem_ready(mem_ready), .mc_issue(mc_issue), .mc_rd(mc_rd), .mc_done(mc_done),
        .stall_front(sf2), .bubble_ex(bf2), .freeze(fz2), .fwd_a(fa2), .fwd_b(fb2),
        .mc_busy(mb2), .err(er2), .stall_cycles(sc2), .loaduse_cnt(lc2));

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Forward source for one EX operand, straight from the priority rule.
    function automatic int src_of(input int r);
        if (r == 0) return 0;
        if (regwrite_mem && rd_mem == r) return 2;
        if (regwrite_wb && rd_wb == r) return 1;
        return 0;
    endfunction

    function automatic void exp_comb(input int k, output bit sf, output bit bf, output bit fz,
                                     output int fa, output int fb, output bit lu);
        bit raw, sb, st, hz;
        raw = 0;
        lu  = 0;
        for (int j = 0; j < 2; j++) begin
            int s;
            bit u;
            s = (j == 0) ? int'(rs1_id) : int'(rs2_id);
            u = (j == 0) ? rs1_used : rs2_used;
            if (id_valid && u && s != 0) begin
                if (fen[k] == 1) begin
                    if (mem_read_ex && rd_ex == s) begin
                        raw = 1;
                        lu  = 1;
                    end
                end else if ((regwrite_ex && rd_ex == s) || (regwrite_mem && rd_mem == s) ||
                             (regwrite_wb && rd_wb == s)) begin
                    raw = 1;
                end
            end
        end
        sb = id_valid && m_pend[k] != 0 &&
             ((rs1_used && rs1_id == m_pend[k]) || (rs2_used && rs2_id == m_pend[k]) ||
              (regwrite_id && rd_id == m_pend[k]));
        st = id_valid && id_is_mc && m_busy[k] != 0;
        hz = raw || sb || st;
        fz = mem_req_mem && !mem_ready;
        sf = hz || fz;
        bf = hz && !fz;
        fa = (fen[k] == 1) ? src_of(rs1_ex) : 0;
        fb = (fen[k] == 1) ? src_of(rs2_ex) : 0;
    endfunction

    // Advance the model by one clock edge using the inputs present before it.
    function automatic void model_update();
        for (int k = 0; k < 3; k++) begin
            bit sf, bf, fz, lu;
            int fa, fb;
            exp_comb(k, sf, bf, fz, fa, fb, lu);
            if (!rst_n) begin
                m_busy[k] = 0; m_pend[k] = 0; m_err[k] = 0; m_sc[k] = 0; m_lc[k] = 0;
            end else begin
                if (sf && m_sc[k] < cmax[k]) m_sc[k]++;
                if (lu && m_lc[k] < cmax[k]) m_lc[k]++;
                if (mc_issue && m_busy[k] != 0) m_err[k] = 1;
                if (m_busy[k] != 0 && mc_done) begin
                    m_busy[k] = 0; m_pend[k] = 0;
                end else if (m_busy[k] == 0 && mc_issue && mc_rd != 0) begin
                    m_busy[k] = 1; m_pend[k] = int'(mc_rd);
                end
            end
        end
    endfunction

    task automatic cmp(input int k, input bit sf, input bit bf, input bit fz, input int fa,
                       input int fb, input bit mb, input bit er, input int sc, input int lc);
        bit esf, ebf, efz, elu;
        int efa, efb;
        exp_comb(k, esf, ebf, efz, efa, efb, elu);
        chk($sformatf("u%0d.stall_front", k), int'(sf), int'(esf));
        chk($sformatf("u%0d.bubble_ex", k), int'(bf), int'(ebf));
        chk($sformatf("u%0d.freeze", k), int'(fz), int'(efz));
        chk($sformatf("u%0d.fwd_a", k), fa, efa);
        chk($sformatf("u%0d.fwd_b", k), fb, efb);
        chk($sformatf("u%0d.mc_busy", k), int'(mb), m_busy[k]);
        chk($sformatf("u%0d.err", k), int'(er), m_err[k]);
        chk($sformatf("u%0d.stall_cycles", k), sc, m_sc[k]);
        chk($sformatf("u%0d.loaduse_cnt", k), lc, m_lc[k]);
    endtask

    // Compare process: every cycle, between edges, all builds against the model.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (chk_en) begin
                cmp(0, sf0, bf0, fz0, int'(fa0), int'(fb0), mb0, er0, int'(sc0), int'(lc0));
                cmp(1, sf1, bf1, fz1, int'(fa1), int'(fb1), mb1, er1, int'(sc1), int'(lc1));
                cmp(2, sf2, bf2, fz2, int'(fa2), int'(fb2), mb2, er2, int'(sc2), int'(lc2));
            end
        end
    end

    task automatic set_idle();
        id_valid = 0; rs1_used = 0; rs2_used = 0; regwrite_id = 0; id_is_mc = 0;
        rs1_id = 0; rs2_id = 0; rd_id = 0; rs1_ex = 0; rs2_ex = 0;
        rd_ex = 0; rd_mem = 0; rd_wb = 0; mc_rd = 0;
        regwrite_ex = 0; regwrite_mem = 0; regwrite_wb = 0;
        mem_read_ex = 0; mem_req_mem = 0; mem_ready = 0; mc_issue = 0; mc_done = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic randomize_inputs();
        rst_n        = ($urandom_range(0, 99) != 0);
        id_valid     = ($urandom_range(0, 3) != 0);
        rs1_id       = 5'($urandom_range(0, 7));
        rs2_id       = 5'($urandom_range(0, 7));
        rd_id        = 5'($urandom_range(0, 7));
        rs1_used     = 1'($urandom_range(0, 1));
        rs2_used     = 1'($urandom_range(0, 1));
        regwrite_id  = 1'($urandom_range(0, 1));
        id_is_mc     = ($urandom_range(0, 5) == 0);
        rs1_ex       = 5'($urandom_range(0, 7));
        rs2_ex       = 5'($urandom_range(0, 7));
        rd_ex        = 5'($urandom_range(0, 7));
        rd_mem       = 5'($urandom_range(0, 7));
        rd_wb        = 5'($urandom_range(0, 7));
        regwrite_ex  = 1'($urandom_range(0, 1));
        regwrite_mem = 1'($urandom_range(0, 1));
        regwrite_wb  = 1'($urandom_range(0, 1));
        mem_read_ex  = ($urandom_range(0, 2) == 0);
        mem_req_mem  = ($urandom_range(0, 2) == 0);
        mem_ready    = 1'($urandom_range(0, 1));
        mc_issue     = ($urandom_range(0, 7) == 0);
        mc_rd        = 5'($urandom_range(0, 15));
        mc_done      = ($urandom_range(0, 5) == 0);
    endtask

    initial begin
        rst_n = 0;
        set_idle();
        tick();
        rst_n  = 1;
        chk_en = 1;
        settle();
        chk("reset mc_busy", int'(mb0), 0);
        chk("reset err", int'(er0), 0);
        chk("reset stall_cycles", int'(sc0), 0);
        chk("reset loaduse_cnt", int'(lc0), 0);
        chk("idle stall_front", int'(sf0), 0);
        chk("idle fwd_a", int'(fa0), 0);
        tick();

        // Load-use, then forward from MEM on the following cycle.
        set_idle();
        id_valid = 1; rs1_id = 5; rs1_used = 1; mem_read_ex = 1; rd_ex = 5; regwrite_ex = 1;
        settle();
        chk("loaduse stall_front", int'(sf0), 1);
        chk("loaduse bubble_ex", int'(bf0), 1);
        tick();
        set_idle();
        id_valid = 1; rs1_id = 5; rs1_used = 1; rs1_ex = 5; rd_mem = 5; regwrite_mem = 1;
        settle();
        chk("after loaduse fwd_a", int'(fa0), 2);
        chk("after loaduse stall_front", int'(sf0), 0);
        chk("loaduse_cnt", int'(lc0), 1);
        chk("stall_cycles after loaduse", int'(sc0), 1);
        chk("nofwd stall on mem", int'(sf1), 1);
        chk("nofwd fwd_a", int'(fa1), 0);
        tick();

        // Double forward and x0 / write-enable cases.
        set_idle();
        regwrite_mem = 1; regwrite_wb = 1; rd_mem = 7; rd_wb = 7; rs2_ex = 7;
        settle();
        chk("double fwd_b mem", int'(fb0), 2);
        tick();
        rd_mem = 0;
        settle();
        chk("rd_mem x0 fwd_b wb", int'(fb0), 1);
        tick();
        rd_mem = 7; regwrite_mem = 0;
        settle();
        chk("no mem write fwd_b", int'(fb0), 1);
        tick();
        regwrite_mem = 1; rd_mem = 0; rd_wb = 0; rs2_ex = 0;
        settle();
        chk("x0 fwd_b", int'(fb0), 0);
        tick();

        // Memory wait of three cycles with a non-forwarding RAW hazard pending.
        set_idle();
        mem_req_mem = 1; mem_ready = 0;
        id_valid = 1; rs2_id = 3; rs2_used = 1; regwrite_wb = 1; rd_wb = 3; rs2_ex = 3;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("memwait freeze", int'(fz0), 1);
            chk("memwait bubble_ex", int'(bf0), 0);
            chk("memwait nofwd bubble_ex", int'(bf1), 0);
            chk("memwait nofwd stall", int'(sf1), 1);
            tick();
        end
        mem_ready = 1;
        settle();
        chk("memdone freeze", int'(fz0), 0);
        chk("memdone stall_front", int'(sf0), 0);
        chk("memwait stall_cycles", int'(sc0), 4);
        chk("nofwd raw stall", int'(sf1), 1);
        chk("nofwd raw bubble", int'(bf1), 1);
        chk("nofwd fwd_b", int'(fb1), 0);
        chk("fwd fwd_b wb", int'(fb0), 1);
        tick();

        // Scoreboard: issue x9, read it, structural and WAW, release after done.
        set_idle();
        mc_issue = 1; mc_rd = 9;
        settle();
        chk("sb issue busy before edge", int'(mb0), 0);
        tick();
        set_idle();
        id_valid = 1; rs1_id = 9; rs1_used = 1;
        settle();
        chk("sb busy", int'(mb0), 1);
        chk("sb raw stall", int'(sf0), 1);
        chk("sb raw bubble", int'(bf0), 1);
        tick();
        set_idle();
        id_valid = 1; id_is_mc = 1; rs1_id = 2; rs1_used = 1;
        settle();
        chk("sb structural stall", int'(sf0), 1);
        tick();
        set_idle();
        id_valid = 1; regwrite_id = 1; rd_id = 9;
        settle();
        chk("sb waw stall", int'(sf0), 1);
        tick();
        set_idle();
        id_valid = 1; rs1_id = 9; rs1_used = 1; mc_done = 1;
        settle();
        chk("sb stall in done cycle", int'(sf0), 1);
        tick();
        mc_done = 0;
        settle();
        chk("sb released", int'(sf0), 0);
        chk("sb busy cleared", int'(mb0), 0);
        tick();

        // Issue together with done while busy -> sticky error.
        set_idle();
        mc_issue = 1; mc_rd = 9;
        tick();
        mc_rd = 10; mc_done = 1;
        settle();
        chk("err before edge", int'(er0), 0);
        tick();
        set_idle();
        settle();
        chk("err set", int'(er0), 1);
        chk("busy after done", int'(mb0), 0);
        tick();
        tick();
        settle();
        chk("err sticky", int'(er0), 1);
        tick();

        // Reset mid-op drops the scoreboard; a later done is ignored.
        mc_issue = 1; mc_rd = 4;
        tick();
        set_idle();
        settle();
        chk("pre-reset busy", int'(mb0), 1);
        rst_n = 0;
        tick();
        rst_n = 1;
        settle();
        chk("post-reset busy", int'(mb0), 0);
        chk("post-reset err", int'(er0), 0);
        chk("post-reset stall_cycles", int'(sc0), 0);
        tick();
        mc_done = 1;
        tick();
        set_idle();
        id_valid = 1; rs1_id = 4; rs1_used = 1;
        settle();
        chk("late done no err", int'(er0), 0);
        chk("reset dropped pending", int'(sf0), 0);
        tick();

        // Saturation: freeze plus load-use for 20 cycles.
        set_idle();
        mem_req_mem = 1; id_valid = 1; rs1_id = 5; rs1_used = 1;
        mem_read_ex = 1; rd_ex = 5; regwrite_ex = 1;
        for (int i = 0; i < 20; i++) tick();
        set_idle();
        settle();
        chk("sat u1 stall_cycles", int'(sc1), 15);
        chk("sat u2 loaduse_cnt", int'(lc2), 7);
        chk("sat u2 stall_cycles", int'(sc2), 7);
        chk("u0 loaduse_cnt 20", int'(lc0), 20);
        chk("u0 stall_cycles 20", int'(sc0), 20);
        tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            randomize_inputs();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
